axi_r_err_gen: RTL and testbench
================================

# axi_r_err_gen

Read-channel error responder for the AXI interconnect. It sits directly upstream of the R-channel buffer on the default (unmapped-address) slave port. It accepts one AR request at a time and produces a complete R burst of `len+1` beats. Every beat carries a fixed error response and fill data, and the final beat asserts `last`. Its R outputs connect one-to-one to the R buffer's slave-side inputs.

## Interface

**Parameters**
- `ID_WIDTH`, 4 — AXI ID width.
- `DATA_WIDTH`, 64 — R data width.
- `USER_WIDTH`, 6 — AXI user width.
- `RESP`, 2'b11 — response code driven on every beat (DECERR).
- `FILL`, 64'hBADC_AB1E_BADC_AB1E — data driven on every beat; truncated or zero-extended to `DATA_WIDTH`.

**Ports**
- `clk_i` — in, 1 — single clock. All logic is rising-edge.
- `rst_ni` — in, 1 — reset. Synchronous, active-low.
- `ar_valid_i` — in, 1 — AR request valid.
- `ar_ready_o` — out, 1 — AR request accepted.
- `ar_id_i` — in, `ID_WIDTH` — request ID.
- `ar_len_i` — in, 8 — burst length minus one (AXI4 encoding).
- `ar_user_i` — in, `USER_WIDTH` — request user bits.
- `r_valid_o` — out, 1 — beat valid (to R buffer `slave_valid_i`).
- `r_data_o` — out, `DATA_WIDTH` — `FILL`.
- `r_resp_o` — out, 2 — `RESP`.
- `r_user_o` — out, `USER_WIDTH` — latched `ar_user_i`.
- `r_id_o` — out, `ID_WIDTH` — latched `ar_id_i`.
- `r_last_o` — out, 1 — final beat of the burst.
- `r_ready_i` — in, 1 — beat accepted (from R buffer `slave_ready_o`).

## Operation

**State machine:** two states, `IDLE` and `BURST`.
- **`IDLE`:**
  - `ar_ready_o` = 1 and `r_valid_o` = 0.
  - On `ar_valid_i & ar_ready_o`: latch id, user, and len into `id_q`, `user_q`, and `cnt_q` (8 bits, remaining beats minus one), then go to `BURST`.
- **`BURST`:**
  - `ar_ready_o` = 0 and `r_valid_o` = 1.
  - `r_last_o` = (`cnt_q == 0`).
  - On `r_valid_o & r_ready_i` with `cnt_q != 0`: decrement `cnt_q`.
  - On `r_valid_o & r_ready_i` with `cnt_q == 0`: go to `IDLE`.
- **Output stability:** `r_id_o` and `r_user_o` equal the latched values throughout `BURST`. They hold their last value in `IDLE` and are 0 after reset. `r_data_o` and `r_resp_o` are constant.
- **Combinational paths:** `ar_ready_o`, `r_valid_o`, and `r_last_o` are decoded from registered state only. There is no combinational path from any input to any output.
- **AXI stability rule:** while `r_valid_o` = 1 and `r_ready_i` = 0, every R output holds unchanged.
- **Arithmetic:** `cnt_q` is 8-bit and never underflows, because the decrement occurs only when `cnt_q != 0`. `ar_len_i` = 255 yields 256 beats.
- **Single outstanding request:** `ar_valid_i` asserted during `BURST` is ignored and not accepted. The upstream holds it per AXI rules.
- **Reset (any state, including mid-burst):**
  - State goes to `IDLE`, `cnt_q` = 0, `id_q` = 0, `user_q` = 0.
  - The burst in progress is abandoned and no further beats are issued.

## Timing

- **Reset values** (on the first edge with `rst_ni` = 0):
  - `ar_ready_o` = 1 (IDLE decode), `r_valid_o` = 0, `r_last_o` = 0.
  - `r_id_o` = 0, `r_user_o` = 0.
  - `r_resp_o` = `RESP`, `r_data_o` = `FILL` (constants).
- **AR → first beat:** AR handshake at edge N gives `r_valid_o` = 1 from cycle N+1. Latency is 1 cycle.
- **Beat rate:** with `r_ready_i` held at 1, one beat per cycle. A burst of length L occupies cycles N+1 through N+L+1.
- **Last beat → next request:** last-beat handshake at edge M gives `ar_ready_o` = 1 in cycle M+1. The earliest next AR handshake is edge M+1. Sustained throughput for L = 0 is one beat per 2 cycles.
- **Backpressure:** `r_ready_i` = 0 stalls indefinitely with no state change. There is no timeout.

## Test plan

- **Reset, then single beat:** hold `rst_ni` = 0 for 3 cycles, then send AR with id = 4'h5, len = 0, user = 6'h2A.
  - During reset: `ar_ready_o` = 1, `r_valid_o` = 0.
  - 1 cycle after AR: one beat with `r_id_o` = 5, `r_user_o` = 2A, `r_resp_o` = 2'b11, `r_data_o` = FILL, `r_last_o` = 1.
  - `ar_ready_o` returns to 1 the following cycle.
- **Burst with random backpressure:** AR len = 7 with `r_ready_i` toggling randomly.
  - Exactly 8 handshakes; `r_last_o` = 1 only on the 8th.
  - R outputs stable whenever valid & !ready.
- **Maximum length:** AR len = 255 with `r_ready_i` = 1.
  - 256 consecutive beats, `r_last_o` only on beat 256.
  - `ar_ready_o` = 1 exactly 1 cycle after the last beat.
- **AR during burst:** hold `ar_valid_i` = 1 with id = 3 during an id = 1, len = 3 burst.
  - No acceptance until `IDLE`; the id = 3 burst starts only after the id = 1 last beat.
  - IDs are never mixed within a burst.
- **Reset mid-burst:** assert `rst_ni` = 0 for 1 cycle after beat 2 of a len = 5 burst.
  - Next cycle: `r_valid_o` = 0, `ar_ready_o` = 1, `r_id_o` = 0.
  - No stray beats follow; a new AR is serviced normally.

Source files
------------

// File: rtl/axi_r_err_gen.sv
// AXI read-channel error responder: accepts one AR at a time and answers it with
// a len+1 beat R burst carrying a fixed error response and fill data.
module axi_r_err_gen #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6,
  parameter logic [1:0]  RESP       = 2'b11,
  parameter logic [63:0] FILL       = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic                  r_last_o,
  input  logic                  r_ready_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      user_q  <= user_d;
    end
  end

  // cnt_q holds remaining beats minus one, so the decrement never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    user_d  = user_q;
    unique case (state_q)
      IDLE: begin
        if (ar_valid_i) begin
          id_d    = ar_id_i;
          user_d  = ar_user_i;
          cnt_d   = ar_len_i;
          state_d = BURST;
        end
      end
      BURST: begin
        if (r_ready_i) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded from registered state only.
  assign ar_ready_o = (state_q == IDLE);
  assign r_valid_o  = (state_q == BURST);
  assign r_last_o   = (state_q == BURST) && (cnt_q == 8'd0);
  assign r_id_o     = id_q;
  assign r_user_o   = user_q;
  assign r_resp_o   = RESP;

  generate
    if (DATA_WIDTH <= 64) begin : g_fill_trunc
      assign r_data_o = FILL[DATA_WIDTH-1:0];
    end else begin : g_fill_ext
      assign r_data_o = {{(DATA_WIDTH-64){1'b0}}, FILL};
    end
  endgenerate

endmodule

// File: tb/tb_axi_r_err_gen.sv
// Scoreboard bench for axi_r_err_gen: a reference model turns each accepted AR into
// its expected list of beats; a negedge monitor checks every cycle against it.
module tb_axi_r_err_gen;

  localparam logic [63:0] FILL_C = 64'hBADC_AB1E_BADC_AB1E;
  localparam logic [1:0]  RESP_C = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ar_valid = 1'b0;
  logic       ar_ready;
  logic [3:0] ar_id = '0;
  logic [7:0] ar_len = '0;
  logic [5:0] ar_user = '0;
  logic       r_valid;
  logic [63:0] r_data;
  logic [1:0] r_resp;
  logic [5:0] r_user;
  logic [3:0] r_id;
  logic       r_last;
  logic       r_ready = 1'b1;

  axi_r_err_gen dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .ar_id_i    (ar_id),
    .ar_len_i   (ar_len),
    .ar_user_i  (ar_user),
    .r_valid_o  (r_valid),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_user_o   (r_user),
    .r_id_o     (r_id),
    .r_last_o   (r_last),
    .r_ready_i  (r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    logic [5:0] user;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] exp_id = '0;
  logic [5:0] exp_user = '0;
  int         vectors = 0;
  int         miscompares = 0;
  int         beats_done = 0;
  logic       rst_seen = 1'b0;
  logic       rmode = 1'b0;
  logic       stall_prev = 1'b0;
  logic [3:0] prev_id;
  logic [5:0] prev_user;
  logic       prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept();
    for (int b = 0; b <= int'(ar_len); b++) begin
      beat_t e;
      e.id   = ar_id;
      e.user = ar_user;
      e.last = (b == int'(ar_len));
      exp_q.push_back(e);
    end
    exp_id   = ar_id;
    exp_user = ar_user;
    $display("AR accepted id=%0h len=%0d user=%0h", ar_id, ar_len, ar_user);
  endtask

  always @(posedge clk) rst_seen <= rst_n;

  always @(posedge clk) begin
    #1;
    r_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: reset state, handshake decode, beat contents and stall stability.
  always @(negedge clk) begin
    if (!rst_seen) begin
      chk("rst_ar_ready", 64'(ar_ready), 64'd1);
      chk("rst_r_valid", 64'(r_valid), 64'd0);
      chk("rst_r_last", 64'(r_last), 64'd0);
      chk("rst_r_id", 64'(r_id), 64'd0);
      chk("rst_r_user", 64'(r_user), 64'd0);
      chk("rst_r_data", r_data, FILL_C);
      chk("rst_r_resp", 64'(r_resp), 64'(RESP_C));
      exp_q.delete();
      exp_id     = '0;
      exp_user   = '0;
      stall_prev = 1'b0;
      if (rst_n && ar_valid) model_accept();
    end else begin
      if (stall_prev) begin
        chk("stall_r_valid", 64'(r_valid), 64'd1);
        chk("stall_r_id", 64'(r_id), 64'(prev_id));
        chk("stall_r_user", 64'(r_user), 64'(prev_user));
        chk("stall_r_last", 64'(r_last), 64'(prev_last));
      end
      chk("ar_ready", 64'(ar_ready), 64'(exp_q.size() == 0));
      chk("r_valid", 64'(r_valid), 64'(exp_q.size() != 0));
      chk("r_last", 64'(r_last), 64'((exp_q.size() != 0) ? exp_q[0].last : 1'b0));
      chk("r_id", 64'(r_id), 64'((exp_q.size() != 0) ? exp_q[0].id : exp_id));
      chk("r_user", 64'(r_user), 64'((exp_q.size() != 0) ? exp_q[0].user : exp_user));
      chk("r_data", r_data, FILL_C);
      chk("r_resp", 64'(r_resp), 64'(RESP_C));
      stall_prev = r_valid && !r_ready;
      prev_id    = r_id;
      prev_user  = r_user;
      prev_last  = r_last;
      if (exp_q.size() != 0) begin
        if (r_ready) begin
          $display("R beat id=%0h user=%0h last=%0b", r_id, r_user, r_last);
          void'(exp_q.pop_front());
          beats_done++;
        end
      end else if (ar_valid) begin
        model_accept();
      end
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [7:0] len, input logic [5:0] user);
    logic hs;
    int   n;
    ar_valid = 1'b1;
    ar_id    = id;
    ar_len   = len;
    ar_user  = user;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = ar_ready && rst_n;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("ar_timeout", 64'd0, 64'd1);
    ar_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int target;
    int n;
    do_reset(3);

    // Single beat right out of reset.
    send_ar(4'h5, 8'd0, 6'h2A);
    wait_idle();

    // len=7 with random backpressure.
    rmode = 1'b1;
    send_ar(4'($urandom_range(0, 15)), 8'd7, 6'($urandom_range(0, 63)));
    wait_idle();

    // Maximum length, full throughput.
    rmode = 1'b0;
    send_ar(4'hA, 8'd255, 6'($urandom_range(0, 63)));
    wait_idle();

    // AR held during a burst must wait for the burst to finish.
    rmode = 1'b1;
    send_ar(4'h1, 8'd3, 6'h11);
    send_ar(4'h3, 8'd2, 6'h33);
    wait_idle();

    // Reset right after the second beat of a len=5 burst.
    rmode = 1'b0;
    target = beats_done + 2;
    send_ar(4'h2, 8'd5, 6'h15);
    n = 0;
    while (beats_done < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (beats_done < target) chk("midrst_timeout", 64'(beats_done), 64'(target));
    #1;
    do_reset(1);
    repeat (3) @(posedge clk);
    #1;
    send_ar(4'h7, 8'd1, 6'h07);
    wait_idle();

    // Random traffic with backpressure.
    rmode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_ar(4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
